// File: rtl/spu_fetch_if.sv
// rtl/spu_fetch_if.sv - fetch-stage bus bundle: LS fetch port, redirect/membusy controls, decode handshake
interface spu_fetch_if #(
    parameter int WIDTH = 32
);
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             membusy;
    logic             fetchinstr;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] instr0;
    logic [WIDTH-1:0] instr1;
    logic             pair_valid;
    logic             pair_ready;
    logic [WIDTH-1:0] out_instr0;
    logic [WIDTH-1:0] out_instr1;
    logic [WIDTH-1:0] out_pc;

    modport master (
        input  redirect, redirect_pc, membusy, instr0, instr1, pair_ready,
        output fetchinstr, adr, pair_valid, out_instr0, out_instr1, out_pc
    );

    modport slave (
        output redirect, redirect_pc, membusy, instr0, instr1, pair_ready,
        input  fetchinstr, adr, pair_valid, out_instr0, out_instr1, out_pc
    );
endinterface

// File: rtl/spu_fetch.sv
// rtl/spu_fetch.sv - cellspu instruction fetch: PC, credit-based dual-word fetch, pair FIFO, redirect flush
module spu_fetch #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RESETPC = '0,
    parameter logic [WIDTH-1:0] LSMASK  = 32'h3FFF
) (
    input  logic         clk,
    input  logic         reset,
    spu_fetch_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inflight_pc;
    logic             inflight;
    logic             drop;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] fifo_pc [DEPTH];
    logic [WIDTH-1:0] fifo_i0 [DEPTH];
    logic [WIDTH-1:0] fifo_i1 [DEPTH];

    logic [CW:0] used;
    logic        issue;
    logic        push;
    logic        pop;

    // Credits count both stored pairs and the one in flight, so a response never finds the FIFO full.
    always_comb begin
        used  = {1'b0, count} + (CW+1)'(inflight);
        issue = !reset && !bus.redirect && !bus.membusy && (used < (CW+1)'(DEPTH));
        // A response landing in a redirect cycle would be flushed on the same edge, so it is not written.
        push  = inflight && !drop && !bus.redirect;
        pop   = bus.pair_valid && bus.pair_ready;
    end

    assign bus.fetchinstr = issue;
    assign bus.adr        = pc & LSMASK;
    assign bus.pair_valid = (count != '0);
    assign bus.out_pc     = fifo_pc[rd_ptr];
    assign bus.out_instr0 = fifo_i0[rd_ptr];
    assign bus.out_instr1 = fifo_i1[rd_ptr];

    // PC, in-flight tracking, drop flag and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESETPC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i] <= '0;
                fifo_i0[i] <= '0;
                fifo_i1[i] <= '0;
            end
        end else begin
            // drop marks the cycle a stale response could still arrive; it lives for one cycle only.
            drop     <= bus.redirect ? inflight : 1'b0;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + WIDTH'(8);
            end
            if (bus.redirect) begin
                pc     <= bus.redirect_pc & ~WIDTH'(7);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr] <= inflight_pc;
                    fifo_i0[wr_ptr] <= bus.instr0;
                    fifo_i1[wr_ptr] <= bus.instr1;
                    wr_ptr          <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_spu_fetch.sv
// tb/tb_spu_fetch.sv - randomized and directed bench for spu_fetch against a queue-level reference model
module tb_spu_fetch;
    localparam int          W    = 32;
    localparam int          D    = 4;
    localparam logic [31:0] MASK = 32'h3FFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spu_fetch_if #(.WIDTH(W)) bus ();

    spu_fetch #(.WIDTH(W), .DEPTH(D), .RESETPC(32'h0), .LSMASK(MASK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: the FIFO is a queue of pair PCs, plus at most one fetch awaiting its data.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          prev_rst;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fetch  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model at the rising edge,
    // then return the instruction pair the memory owes for the fetch just issued.
    task automatic step(input bit rst, input bit red, input logic [31:0] rpc, input bit busy, input bit rdy);
        bit          exp_issue;
        bit          issued;
        logic [31:0] iss_adr;
        reset           = rst;
        bus.redirect    = red;
        bus.redirect_pc = rpc;
        bus.membusy     = busy;
        bus.pair_ready  = rdy;
        @(negedge clk);
        exp_issue = !rst && !red && !busy && ((m_q.size() + int'(m_pend)) < D);
        check("fetchinstr", {31'b0, bus.fetchinstr}, {31'b0, exp_issue});
        check("adr", bus.adr, m_pc & MASK);
        check("pair_valid", {31'b0, bus.pair_valid}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check("out_pc", bus.out_pc, m_q[0]);
            check("out_instr0", bus.out_instr0, (m_q[0] & MASK) >> 2);
            check("out_instr1", bus.out_instr1, ((m_q[0] & MASK) >> 2) + 32'd1);
        end else if (rst && prev_rst) begin
            check("reset_out_pc", bus.out_pc, 32'h0);
            check("reset_out_instr0", bus.out_instr0, 32'h0);
            check("reset_out_instr1", bus.out_instr1, 32'h0);
        end
        issued  = bus.fetchinstr;
        iss_adr = bus.adr;
        if (issued) n_fetch++;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_pend = 1'b0;
            m_pc   = 32'h0;
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (red) begin
                m_q.delete();
                m_pend = 1'b0;
                m_pc   = rpc & ~32'h7;
            end else begin
                if (m_pend) m_q.push_back(m_pend_pc);
                m_pend = exp_issue;
                if (exp_issue) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd8;
                end
            end
        end
        prev_rst = rst;
        #1;
        bus.instr0 = issued ? (iss_adr >> 2)         : $urandom;
        bus.instr1 = issued ? ((iss_adr >> 2) + 32'd1) : $urandom;
    endtask

    initial begin
        int f0;
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.membusy     = 1'b0;
        bus.pair_ready  = 1'b0;
        bus.instr0      = '0;
        bus.instr1      = '0;
        m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = '0; prev_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, then streaming with decode always ready.
        step(1, 0, 0, 0, 1);
        repeat (12) step(0, 0, 0, 0, 1);

        // Backpressure from reset: exactly DEPTH fetches, then in-order drain.
        step(1, 0, 0, 0, 0);
        f0 = n_fetch;
        repeat (10) step(0, 0, 0, 0, 0);
        check("fetches_while_stalled", n_fetch - f0, D);
        repeat (10) step(0, 0, 0, 0, 1);

        // Redirect with a fetch in flight.
        step(0, 1, 32'h105, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);

        // membusy for three cycles mid-stream while the FIFO drains.
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // Redirect coinciding with a handshake on a full FIFO.
        repeat (6) step(0, 0, 0, 0, 0);
        step(0, 1, 32'h2000, 0, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // Redirect together with membusy.
        step(0, 1, 32'h48, 1, 1);
        repeat (4) step(0, 0, 0, 0, 1);

        // PC wraparound and address masking.
        step(0, 1, 32'hFFFF_FFF8, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);

        // Reset mid-stream.
        repeat (2) step(1, 0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) == 0),
                 $urandom,
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
